// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot loader and fetch arbiter for the instruction RAM.
// Loader bytes pack little-endian into words; the CPU reads only in RUN.
module imem_load_ctrl #(
  parameter int MAX_WORDS = 1024,
  parameter int LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start_i,
  input  logic [LEN_W-1:0] load_len_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  input  logic [31:0]      fetch_addr_i,
  output logic [31:0]      fetch_instr_o,
  output logic             cpu_run_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      addr_imem_ram_o,
  output logic [31:0]      wr_instr_imem_ram_o,
  output logic             wr_en_imem_ram_o,
  input  logic [31:0]      read_instr_imem_ram_i
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    RUN
  } state_t;

  localparam logic [LEN_W:0]   MAX_L = (LEN_W+1)'(MAX_WORDS);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] word_idx;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       byte_cnt;
  logic [31:0]      shift_q;
  logic             len_ok;
  logic             last_word;

  assign len_ok    = (load_len_i != '0) &&
                     ({1'b0, load_len_i} <= MAX_L);
  assign last_word = (word_idx == len_q - ONE);

  // Sequencer: state, counters, word assembly and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      word_idx         <= '0;
      len_q            <= '0;
      byte_cnt         <= '0;
      shift_q          <= '0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      cpu_run_o        <= 1'b0;
      byte_ready_o     <= 1'b0;
      wr_en_imem_ram_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (load_start_i) begin
            if (len_ok) begin
              state        <= COLLECT;
              len_q        <= load_len_i;
              word_idx     <= '0;
              byte_cnt     <= '0;
              shift_q      <= '0;
              cpu_run_o    <= 1'b0;
              byte_ready_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (byte_valid_i && byte_ready_o) begin
            shift_q[{byte_cnt, 3'b000} +: 8] <= byte_data_i;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state            <= WRITE;
              byte_ready_o     <= 1'b0;
              wr_en_imem_ram_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          wr_en_imem_ram_o <= 1'b0;
          word_idx         <= word_idx + ONE;
          byte_cnt         <= '0;
          if (last_word) begin
            state     <= RUN;
            cpu_run_o <= 1'b1;
            done_o    <= 1'b1;
          end else begin
            state        <= COLLECT;
            byte_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port mux: CPU owns the address in RUN, loader otherwise.
  always_comb begin
    addr_imem_ram_o     = {{(32-LEN_W){1'b0}}, word_idx};
    wr_instr_imem_ram_o = shift_q;
    fetch_instr_o       = 32'h0000_0000;
    if (cpu_run_o) begin
      addr_imem_ram_o = fetch_addr_i;
      fetch_instr_o   = read_instr_imem_ram_i;
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: randomized loads checked against a word-level
// image model and a simple RAM attached to the controller.
module tb_imem_load_ctrl;

  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start;
  logic [10:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready_o;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr_o;
  logic        cpu_run_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        wr_en_o;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int oob = 0;
  int ovl = 0;

  logic [31:0] ram [MAXW];
  logic [31:0] exp_mem [MAXW];
  logic [31:0] wq_a [$];
  logic [31:0] wq_d [$];
  logic [31:0] w0, w1;

  imem_load_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .load_start_i          (load_start),
    .load_len_i            (load_len),
    .byte_valid_i          (byte_valid),
    .byte_data_i           (byte_data),
    .byte_ready_o          (byte_ready_o),
    .fetch_addr_i          (fetch_addr),
    .fetch_instr_o         (fetch_instr_o),
    .cpu_run_o             (cpu_run_o),
    .done_o                (done_o),
    .err_o                 (err_o),
    .addr_imem_ram_o       (addr_o),
    .wr_instr_imem_ram_o   (wdata_o),
    .wr_en_imem_ram_o      (wr_en_o),
    .read_instr_imem_ram_i (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM and write/pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en_o) begin
      wq_a.push_back(addr_o);
      wq_d.push_back(wdata_o);
      if (addr_o < MAXW) ram[addr_o[9:0]] = wdata_o;
      else oob++;
      if (cpu_run_o || byte_ready_o) ovl++;
    end
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outs();
    check("rst_run", cpu_run_o, 0);
    check("rst_ready", byte_ready_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_wen", wr_en_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_fetch", fetch_instr_o, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    rd_data    = $urandom;
    #1;
    check("nop_fetch", fetch_instr_o, 0);
    n = 0;
    while (byte_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("byte_ready", byte_ready_o, 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_load(input int len, input int gap,
                         input bit fixed, input bit poke);
    logic [31:0] w;
    int c0, n, d0, e0, sz;
    wq_a.delete();
    wq_d.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    load_start = 1'b1;
    load_len   = 11'(len);
    @(negedge clk);
    load_start = 1'b0;
    c0 = cyc;
    check("run_fall", cpu_run_o, 0);
    check("ready_rise", byte_ready_o, 1);
    for (int k = 0; k < len; k++) begin
      w = fixed ? 32'h4433_2211 + 32'(k) * 32'h4444_4444 : $urandom;
      exp_mem[k] = w;
      for (int j = 0; j < 4; j++) begin
        if (poke && k == 0 && j == 1) begin
          load_start = 1'b1;
          load_len   = 11'd0;
          @(negedge clk);
          load_start = 1'b0;
        end
        send_byte(w[8*j +: 8], gap);
      end
    end
    n = 0;
    while (done_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_o, 1);
    check("run_rise", cpu_run_o, 1);
    if (gap == 0) check("load_cycles", cyc - c0, 5 * len);
    @(negedge clk);
    check("done_pulse", done_o, 0);
    check("done_count", done_cnt - d0, 1);
    check("err_ignored", err_cnt - e0, 0);
    check("wr_count", wq_a.size(), len);
    sz = (wq_a.size() < len) ? wq_a.size() : len;
    for (int k = 0; k < sz; k++) begin
      check("wr_addr", wq_a[k], k);
      check("wr_data", wq_d[k], exp_mem[k]);
    end
    check("no_oob", oob, 0);
    check("no_overlap", ovl, 0);
  endtask

  task automatic fetch_loop(input int len);
    int a;
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(len - 1, 0);
      fetch_addr = a;
      rd_data    = ram[a];
      #1;
      check("fetch_addr", addr_o, a);
      check("fetch_data", fetch_instr_o, exp_mem[a]);
      check("fetch_wen", wr_en_o, 0);
      @(negedge clk);
    end
  endtask

  task automatic bad_start(input int len);
    logic run0;
    int e0, w0n;
    run0 = cpu_run_o;
    e0   = err_cnt;
    w0n  = wq_a.size();
    load_start = 1'b1;
    load_len   = 11'(len);
    @(negedge clk);
    load_start = 1'b0;
    check("err_pulse", err_o, 1);
    check("err_run_kept", cpu_run_o, run0);
    check("err_no_ready", byte_ready_o, 0);
    @(negedge clk);
    check("err_clear", err_o, 0);
    check("err_count", err_cnt - e0, 1);
    check("err_no_write", wq_a.size(), w0n);
    check("err_run_kept2", cpu_run_o, run0);
  endtask

  initial begin
    load_start = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    fetch_addr = '0;
    rd_data    = 32'hA5A5_5A5A;
    #12;
    check_idle_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(2, 0, 1'b1, 1'b0);
    fetch_addr = 32'd5;
    rd_data    = 32'hDEAD_BEEF;
    #1;
    check("run_addr5", addr_o, 32'd5);
    check("run_instr", fetch_instr_o, 32'hDEAD_BEEF);
    check("run_wen", wr_en_o, 0);
    @(negedge clk);
    fetch_loop(2);
    bad_start(0);
    bad_start(1025);
    check("run_after_bad", cpu_run_o, 1);

    do_load(1, 3, 1'b0, 1'b1);
    fetch_loop(1);

    rst_n = 1'b0;
    #1;
    check_idle_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bad_start(0);
    bad_start(1025);

    for (int r = 0; r < 3; r++) begin
      do_load($urandom_range(6, 1), $urandom_range(2, 0), 1'b0, 1'b0);
      fetch_loop(1);
    end

    wq_a.delete();
    wq_d.delete();
    w0 = $urandom;
    w1 = $urandom;
    load_start = 1'b1;
    load_len   = 11'd2;
    @(negedge clk);
    load_start = 1'b0;
    for (int j = 0; j < 4; j++) send_byte(w0[8*j +: 8], 0);
    for (int j = 0; j < 2; j++) send_byte(w1[8*j +: 8], 0);
    rst_n = 1'b0;
    #1;
    check_idle_outs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("part_wr_count", wq_a.size(), 1);
    if (wq_a.size() > 0) begin
      check("part_wr_addr", wq_a[0], 0);
      check("part_wr_data", wq_d[0], w0);
    end
    check("part_run", cpu_run_o, 0);

    do_load(MAXW, 0, 1'b0, 1'b0);
    check("full_last_addr", wq_a[wq_a.size()-1], MAXW - 1);
    fetch_loop(MAXW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
